// File: rtl/matrix_add_pkg.sv
// Shared sizing helpers and signed-saturation functions for the streaming matrix adder.
package matrix_add_pkg;

  localparam int SAT_CNT_W = 16;
  localparam int MAX_DW    = 32;
  localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

  function automatic int calc_beats(input int rows, input int cols, input int lanes);
    return (rows * cols) / lanes;
  endfunction

  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Lane 0 sits at the MSBs of a packed lane vector.
  function automatic int lane_lsb(input int lane, input int lanes, input int dw);
    return (lanes - 1 - lane) * dw;
  endfunction

  function automatic logic sat_ovf(input logic signed [MAX_DW:0] sum, input int dw);
    logic signed [MAX_DW:0] w_one;
    logic signed [MAX_DW:0] w_hi;
    logic signed [MAX_DW:0] w_lo;
    w_one = {{MAX_DW{1'b0}}, 1'b1};
    w_hi  = (w_one <<< (dw - 1)) - w_one;
    w_lo  = -(w_one <<< (dw - 1));
    return (sum > w_hi) || (sum < w_lo);
  endfunction

  function automatic logic signed [MAX_DW:0] sat_clip(input logic signed [MAX_DW:0] sum,
                                                      input int dw);
    logic signed [MAX_DW:0] w_one;
    logic signed [MAX_DW:0] w_hi;
    logic signed [MAX_DW:0] w_lo;
    w_one = {{MAX_DW{1'b0}}, 1'b1};
    w_hi  = (w_one <<< (dw - 1)) - w_one;
    w_lo  = -(w_one <<< (dw - 1));
    if (sum > w_hi) begin
      return w_hi;
    end else if (sum < w_lo) begin
      return w_lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/matrix_add_fifo.sv
// Synchronous FIFO with occupancy count; zero read latency, head data forced to 0 when empty.
// A push while full is only taken alongside a pop; a pop while empty is ignored.
module matrix_add_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [W-1:0]             i_wr_dat,
  input  logic                     i_rd_en,
  output logic [W-1:0]             o_rd_dat,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_rd    = i_rd_en && !w_empty;
  assign w_wr    = i_wr_en && (!w_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale entries stay invisible after a reset because the head is masked while empty.
  assign o_rd_dat = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count  = r_count;

endmodule

// File: rtl/matrix_add_axis_pipe.sv
// Streaming element-wise S = A + B, LANES per beat: 2-clock latency, 1 beat/clk, registered credit into the output FIFO.
// Lanes wrap by default; defining MATRIX_ADD_SAT_EN saturates each lane and counts clipped lanes in sat_count.
module matrix_add_axis_pipe
  import matrix_add_pkg::*;
#(
  parameter int DW         = 16,
  parameter int ROWS       = 10,
  parameter int COLS       = 12,
  parameter int LANES      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [2*LANES*DW-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [LANES*DW-1:0]    m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   frame_err,
  output logic [SAT_CNT_W-1:0]   sat_count
);

  localparam int BEATS  = calc_beats(ROWS, COLS, LANES);
  localparam int CNT_W  = calc_cnt_w(BEATS);
  localparam int LW     = LANES * DW;
  localparam int FW     = LW + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W  = FCNT_W + 1;

  logic                w_accept;
  logic                w_pop;
  logic                w_cnt_last;
  logic [LW-1:0]       w_sum_dat;
  logic [FW-1:0]       w_fifo_dat;
  logic [FCNT_W-1:0]   w_fifo_cnt;
  logic [OCC_W-1:0]    w_occ_nxt;

  logic [CNT_W-1:0]    r_beat_cnt;
  logic                r_credit;
  logic                r_frame_err;
  logic                r_stage_vld;
  logic                r_stage_last;
  logic [LW-1:0]       r_stage_dat;

`ifdef MATRIX_ADD_SAT_EN
  localparam int NSAT_W = $clog2(LANES + 1);
  logic [LANES-1:0]    w_sat_lane;
  logic [NSAT_W-1:0]   w_nsat;
  logic [NSAT_W-1:0]   r_stage_nsat;
  logic [SAT_CNT_W:0]  w_sat_sum;
  logic [SAT_CNT_W-1:0] r_sat_cnt;
`endif

  assign s_axis_tready = enable && r_credit;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_cnt_last    = (r_beat_cnt == CNT_W'(BEATS - 1));

  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [DW-1:0] w_a;
    logic signed [DW-1:0] w_b;
    assign w_a = s_axis_tdata[LW + lane_lsb(gi, LANES, DW) +: DW];
    assign w_b = s_axis_tdata[lane_lsb(gi, LANES, DW) +: DW];
`ifdef MATRIX_ADD_SAT_EN
    logic signed [DW:0] w_wide;
    assign w_wide         = {w_a[DW-1], w_a} + {w_b[DW-1], w_b};
    assign w_sat_lane[gi] = sat_ovf((MAX_DW+1)'(w_wide), DW);
    assign w_sum_dat[lane_lsb(gi, LANES, DW) +: DW] = DW'(sat_clip((MAX_DW+1)'(w_wide), DW));
`else
    assign w_sum_dat[lane_lsb(gi, LANES, DW) +: DW] = w_a + w_b;
`endif
  end

`ifdef MATRIX_ADD_SAT_EN
  always_comb begin
    w_nsat = '0;
    for (int i = 0; i < LANES; i++) begin
      w_nsat = w_nsat + NSAT_W'(w_sat_lane[i]);
    end
  end
`endif

  // An early upstream tlast restarts the frame so the output tlast realigns to the input.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat_cnt  <= '0;
      r_frame_err <= 1'b0;
    end else if (w_accept) begin
      if (w_cnt_last || s_axis_tlast) begin
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (s_axis_tlast != w_cnt_last) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stage_vld  <= 1'b0;
      r_stage_last <= 1'b0;
      r_stage_dat  <= '0;
`ifdef MATRIX_ADD_SAT_EN
      r_stage_nsat <= '0;
`endif
    end else begin
      r_stage_vld <= w_accept;
      if (w_accept) begin
        r_stage_last <= w_cnt_last;
        r_stage_dat  <= w_sum_dat;
`ifdef MATRIX_ADD_SAT_EN
        r_stage_nsat <= w_nsat;
`endif
      end
    end
  end

  matrix_add_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (aclk),
    .rst_n    (aresetn),
    .i_wr_en  (r_stage_vld),
    .i_wr_dat ({r_stage_last, r_stage_dat}),
    .i_rd_en  (w_pop),
    .o_rd_dat (w_fifo_dat),
    .o_count  (w_fifo_cnt)
  );

  assign m_axis_tvalid = (w_fifo_cnt != '0);
  assign m_axis_tlast  = w_fifo_dat[FW-1];
  assign m_axis_tdata  = w_fifo_dat[LW-1:0];
  assign w_pop         = m_axis_tvalid && m_axis_tready;

  // The stage register counts as occupied, so an accepted beat always has a FIFO slot next cycle.
  assign w_occ_nxt = OCC_W'(w_fifo_cnt) + OCC_W'(r_stage_vld) + OCC_W'(w_accept) - OCC_W'(w_pop);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_credit <= 1'b0;
    end else begin
      r_credit <= (w_occ_nxt < OCC_W'(FIFO_DEPTH));
    end
  end

  assign frame_err = r_frame_err;

`ifdef MATRIX_ADD_SAT_EN
  assign w_sat_sum = {1'b0, r_sat_cnt} + (SAT_CNT_W+1)'(r_stage_nsat);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sat_cnt <= '0;
    end else if (r_stage_vld) begin
      r_sat_cnt <= w_sat_sum[SAT_CNT_W] ? SAT_CNT_MAX : w_sat_sum[SAT_CNT_W-1:0];
    end
  end

  assign sat_count = r_sat_cnt;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_matrix_add_axis_pipe.sv
// Scoreboard bench: directed frames on the default-size adder, random handshakes on a small instance.
module tb_matrix_add_axis_pipe;

  localparam int DW     = 16;
  localparam int LANES  = 12;
  localparam int LW     = LANES * DW;
  localparam int DW2    = 8;
  localparam int LANES2 = 3;
  localparam int LW2    = LANES2 * DW2;
  localparam int BEATS2 = 8;
  localparam int N2     = 48;

`ifdef MATRIX_ADD_SAT_EN
  localparam logic [DW-1:0] T3_L0  = 16'h7FFF;
  localparam logic [DW-1:0] T3_L1  = 16'h8000;
  localparam logic [DW-1:0] T3_L11 = 16'h7FFF;
  localparam int            T3_SAT = 3;
`else
  localparam logic [DW-1:0] T3_L0  = 16'h8000;
  localparam logic [DW-1:0] T3_L1  = 16'h0000;
  localparam logic [DW-1:0] T3_L11 = 16'hFFFE;
  localparam int            T3_SAT = 0;
`endif

  typedef struct packed { logic last; logic [LW-1:0]  dat; } beat0_t;
  typedef struct packed { logic last; logic [LW2-1:0] dat; } beat2_t;

  logic            aclk     = 1'b0;
  logic            aresetn  = 1'b0;
  logic            enable   = 1'b0;
  logic [2*LW-1:0] s_tdata  = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tlast  = 1'b0;
  logic            s_tready;
  logic [LW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready = 1'b0;
  logic            frame_err;
  logic [15:0]     sat_count;

  logic [2*LW2-1:0] s2_tdata  = '0;
  logic             s2_tvalid = 1'b0;
  logic             s2_tlast  = 1'b0;
  logic             s2_tready;
  logic [LW2-1:0]   m2_tdata;
  logic             m2_tvalid;
  logic             m2_tlast;
  logic             m2_tready = 1'b1;
  logic             frame_err2;
  logic [15:0]      sat_count2;

  matrix_add_axis_pipe u_dut (
    .aclk (aclk), .aresetn (aresetn), .enable (enable),
    .s_axis_tdata (s_tdata), .s_axis_tvalid (s_tvalid), .s_axis_tlast (s_tlast),
    .s_axis_tready (s_tready), .m_axis_tdata (m_tdata), .m_axis_tvalid (m_tvalid),
    .m_axis_tlast (m_tlast), .m_axis_tready (m_tready), .frame_err (frame_err),
    .sat_count (sat_count)
  );

  matrix_add_axis_pipe #(.DW(DW2), .ROWS(4), .COLS(6), .LANES(LANES2), .FIFO_DEPTH(4)) u_small (
    .aclk (aclk), .aresetn (aresetn), .enable (enable),
    .s_axis_tdata (s2_tdata), .s_axis_tvalid (s2_tvalid), .s_axis_tlast (s2_tlast),
    .s_axis_tready (s2_tready), .m_axis_tdata (m2_tdata), .m_axis_tvalid (m2_tvalid),
    .m_axis_tlast (m2_tlast), .m_axis_tready (m2_tready), .frame_err (frame_err2),
    .sat_count (sat_count2)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int     checks = 0;
  int     errors = 0;
  beat0_t exp_q[$];
  beat2_t exp2_q[$];
  int     pop_cyc_q[$];
  int     acc_cnt = 0;
  int     last_acc_cyc = 0;
  int     first_vld_cyc = 0;
  bit     seen_vld = 0;
  bit     t6_run = 0;
  int     out2_cnt = 0;
  int     sat2_exp = 0;
  beat0_t m0_e;
  beat2_t m2_e;

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [LW-1:0] fill(input logic [DW-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [LW-1:0] put_lane(input logic [LW-1:0] vec, input int i,
                                             input logic [DW-1:0] v);
    vec[(LANES-1-i)*DW +: DW] = v;
    return vec;
  endfunction

  // Output monitors: pop the expected beat whenever a handshake is pending at the next edge.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && !seen_vld) begin
      seen_vld      = 1'b1;
      first_vld_cyc = cyc;
    end
    if (aresetn && m_tvalid && m_tready) begin
      pop_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out0_unexpected got=beat %0h want=no beat", m_tdata);
      end else begin
        m0_e = exp_q.pop_front();
        if (m_tdata !== m0_e.dat || m_tlast !== m0_e.last) begin
          errors++;
          $display("FAIL out0_beat got=%0h last=%b want=%0h last=%b",
                   m_tdata, m_tlast, m0_e.dat, m0_e.last);
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (aresetn && m2_tvalid && m2_tready) begin
      out2_cnt++;
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL out2_unexpected got=beat %0h want=no beat", m2_tdata);
      end else begin
        m2_e = exp2_q.pop_front();
        if (m2_tdata !== m2_e.dat || m2_tlast !== m2_e.last) begin
          errors++;
          $display("FAIL out2_beat got=%0h last=%b want=%0h last=%b",
                   m2_tdata, m2_tlast, m2_e.dat, m2_e.last);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (t6_run) m2_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send0(input logic [LW-1:0] a, input logic [LW-1:0] b, input logic tl,
                       input logic [LW-1:0] ev, input logic el);
    bit     got;
    beat0_t e;
    got      = 1'b0;
    s_tdata  = {a, b};
    s_tlast  = tl;
    s_tvalid = 1'b1;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge aclk);
      if (s_tready) begin
        @(posedge aclk);
        #1;
        got = 1'b1;
      end
    end
    s_tvalid = 1'b0;
    if (got) begin
      e.last = el;
      e.dat  = ev;
      exp_q.push_back(e);
      acc_cnt++;
      last_acc_cyc = cyc;
    end else begin
      checks++;
      errors++;
      $display("FAIL send0_timeout got=no accept want=accept");
    end
  endtask

  task automatic send2(input int n);
    logic [LW2-1:0]        a, b, ev;
    logic signed [DW2-1:0] la, lb;
    int                    s, idle;
    bit                    got;
    beat2_t                e;
    a = LW2'($urandom);
    b = LW2'($urandom);
    for (int l = 0; l < LANES2; l++) begin
      la = a[(LANES2-1-l)*DW2 +: DW2];
      lb = b[(LANES2-1-l)*DW2 +: DW2];
      s  = int'(la) + int'(lb);
`ifdef MATRIX_ADD_SAT_EN
      if (s > 127) begin
        s = 127;
        sat2_exp++;
      end else if (s < -128) begin
        s = -128;
        sat2_exp++;
      end
`endif
      ev[(LANES2-1-l)*DW2 +: DW2] = DW2'(s);
    end
    idle = 0;
    while ($urandom_range(0, 1) == 1 && idle < 6) begin
      @(posedge aclk);
      #1;
      idle++;
    end
    got       = 1'b0;
    s2_tdata  = {a, b};
    s2_tlast  = ((n % BEATS2) == BEATS2 - 1);
    s2_tvalid = 1'b1;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge aclk);
      if (s2_tready) begin
        @(posedge aclk);
        #1;
        got = 1'b1;
      end
    end
    s2_tvalid = 1'b0;
    if (got) begin
      e.last = ((n % BEATS2) == BEATS2 - 1);
      e.dat  = ev;
      exp2_q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL send2_timeout got=no accept want=accept");
    end
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge aclk);
    chk(name, LW'(exp_q.size()), '0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] va, vb, ve, hold_dat;
    logic          hold_last;
    bit            sdone;
    int            t1_first;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_tready",  LW'(s_tready),  '0);
    chk("rst_m_tvalid",  LW'(m_tvalid),  '0);
    chk("rst_m_tdata",   m_tdata,        '0);
    chk("rst_m_tlast",   LW'(m_tlast),   '0);
    chk("rst_frame_err", LW'(frame_err), '0);
    chk("rst_sat_count", LW'(sat_count), '0);
    aresetn  = 1'b1;
    enable   = 1'b1;
    m_tready = 1'b1;
    @(posedge aclk);
    #1;

    // T1: back-to-back frame, all lanes 1 + 2
    pop_cyc_q.delete();
    t1_first = 0;
    for (int j = 1; j <= 10; j++) begin
      send0(fill(16'd1), fill(16'd2), j == 10, fill(16'd3), j == 10);
      if (j == 1) t1_first = last_acc_cyc;
    end
    wait_drain("t1_drain");
    chk("t1_latency",    LW'(first_vld_cyc - t1_first), LW'(1));
    chk("t1_in_rate",    LW'(last_acc_cyc - t1_first), LW'(9));
    chk("t1_out_count",  LW'(pop_cyc_q.size()), LW'(10));
    if (pop_cyc_q.size() == 10) chk("t1_out_rate", LW'(pop_cyc_q[9] - pop_cyc_q[0]), LW'(9));

    // T2: output stalled, credit runs out after FIFO_DEPTH accepts
    m_tready = 1'b0;
    acc_cnt  = 0;
    sdone    = 1'b0;
    fork
      begin
        for (int j = 0; j < 10; j++)
          send0(fill(16'(j + 1)), fill(16'd100), j == 9, fill(16'(j + 101)), j == 9);
        sdone = 1'b1;
      end
    join_none
    repeat (12) @(negedge aclk);
    chk("t2_accepts",  LW'(acc_cnt),  LW'(4));
    chk("t2_s_tready", LW'(s_tready), '0);
    chk("t2_m_tvalid", LW'(m_tvalid), LW'(1));
    hold_dat  = m_tdata;
    hold_last = m_tlast;
    chk("t2_head", hold_dat, fill(16'd101));
    repeat (5) @(negedge aclk);
    chk("t2_hold_dat",  m_tdata, hold_dat);
    chk("t2_hold_last", LW'(m_tlast), LW'(hold_last));
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    for (int t = 0; t < 400 && !sdone; t++) @(negedge aclk);
    chk("t2_sender_done", LW'(sdone), LW'(1));
    wait_drain("t2_drain");

    // T3: overflow corner cases
    va = '0;
    vb = '0;
    ve = '0;
    va = put_lane(va, 0, 16'h7FFF); vb = put_lane(vb, 0, 16'h0001); ve = put_lane(ve, 0, T3_L0);
    va = put_lane(va, 1, 16'h8000); vb = put_lane(vb, 1, 16'h8000); ve = put_lane(ve, 1, T3_L1);
    va = put_lane(va, 2, 16'h0005); vb = put_lane(vb, 2, 16'hFFF9); ve = put_lane(ve, 2, 16'hFFFE);
    send0(va, vb, 1'b0, ve, 1'b0);
    va = put_lane('0, 11, 16'h7FFF);
    ve = put_lane('0, 11, T3_L11);
    send0(va, va, 1'b0, ve, 1'b0);
    for (int j = 3; j <= 10; j++) send0('0, '0, j == 10, '0, j == 10);
    wait_drain("t3_drain");
    chk("t3_sat_count", LW'(sat_count), LW'(T3_SAT));

    // T4: early upstream tlast on beat 5
    chk("t4_err_before", LW'(frame_err), '0);
    for (int j = 1; j <= 15; j++)
      send0(fill(16'(j)), fill(16'(2 * j)), (j == 5) || (j == 15), fill(16'(3 * j)), j == 15);
    wait_drain("t4_drain");
    chk("t4_err_after", LW'(frame_err), LW'(1));

    // T5: async reset with three beats parked in the FIFO
    m_tready = 1'b0;
    for (int j = 1; j <= 3; j++) send0(fill(16'(j)), '0, 1'b0, fill(16'(j)), 1'b0);
    repeat (3) @(negedge aclk);
    chk("t5_pre_vld", LW'(m_tvalid), LW'(1));
    #2;
    aresetn = 1'b0;
    #1;
    chk("t5_s_tready",  LW'(s_tready),  '0);
    chk("t5_m_tvalid",  LW'(m_tvalid),  '0);
    chk("t5_m_tdata",   m_tdata,        '0);
    chk("t5_m_tlast",   LW'(m_tlast),   '0);
    chk("t5_frame_err", LW'(frame_err), '0);
    chk("t5_sat_count", LW'(sat_count), '0);
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn  = 1'b1;
    m_tready = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      send0(fill(16'(7 * j)), fill(16'(-j)), j == 10, fill(16'(6 * j)), j == 10);
      if (j == 4) begin
        enable = 1'b0;
        repeat (3) @(negedge aclk);
        chk("t5_enable_low", LW'(s_tready), '0);
        @(posedge aclk);
        #1;
        enable = 1'b1;
      end
    end
    wait_drain("t5_drain");
    chk("t5_err_after", LW'(frame_err), '0);
    chk("t5_sat_after", LW'(sat_count), '0);

    // T6: small instance, random valid gaps and random ready
    t6_run = 1'b1;
    for (int n = 0; n < N2; n++) send2(n);
    for (int t = 0; t < 1000 && exp2_q.size() != 0; t++) @(negedge aclk);
    t6_run = 1'b0;
    @(posedge aclk);
    #1;
    m2_tready = 1'b1;
    chk("t6_drain",     LW'(exp2_q.size()), '0);
    chk("t6_out_count", LW'(out2_cnt),      LW'(N2));
    chk("t6_frame_err", LW'(frame_err2),    '0);
    chk("t6_sat_count", LW'(sat_count2),    LW'(sat2_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
